// File: rtl/ssd_scan_decoder.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: recovers the digit shown per anode.
// Optional macro SSD_HEX_DECODE_EN adds the A-F glyphs to the decode table.
module ssd_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              seg,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_seen,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic                    frame_valid,
    output logic                    err_pattern,
    output logic                    err_anode
);

    localparam int BUS_W = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE      = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] value;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] s);
        dec_t d;
        d = '{valid: 1'b1, blank: 1'b0, value: 4'h0};
        case (s)
            7'b1000000: d.value = 4'h0;
            7'b1111001: d.value = 4'h1;
            7'b0100100: d.value = 4'h2;
            7'b0110000: d.value = 4'h3;
            7'b0011001: d.value = 4'h4;
            7'b0010010: d.value = 4'h5;
            7'b0000010: d.value = 4'h6;
            7'b1111000: d.value = 4'h7;
            7'b0000000: d.value = 4'h8;
            7'b0010000: d.value = 4'h9;
            7'b1111111: begin
                d.value = 4'hF;
                d.blank = 1'b1;
            end
`ifdef SSD_HEX_DECODE_EN
            7'b0001000: d.value = 4'hA;
            7'b0000011: d.value = 4'hB;
            7'b1000110: d.value = 4'hC;
            7'b0100001: d.value = 4'hD;
            7'b0000110: d.value = 4'hE;
            7'b0001110: d.value = 4'hF;
`endif
            default:    d.valid = 1'b0;
        endcase
        return d;
    endfunction

    logic [BUS_W-1:0]        sync1_q, sync2_q, last_q;
    logic [CNT_W-1:0]        cnt_q;
    state_e                  state_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   seen_q, blank_q;
    logic                    err_pattern_q, err_anode_q;

    // Capture always works on last_q, the value that was proven stable, not the live sample.
    logic [NUM_DIGITS-1:0] cap_an_low;
    logic                  cap_idle, cap_multi;
    dec_t                  cap_dec;

    assign cap_an_low = ~last_q[BUS_W-1:7];
    assign cap_idle   = (cap_an_low == '0);
    assign cap_multi  = ((cap_an_low & (cap_an_low - AN_ONE)) != '0);
    assign cap_dec    = decode(last_q[6:0]);

    // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            last_q        <= '1;
            cnt_q         <= '0;
            state_q       <= IDLE;
            digits_q      <= '0;
            seen_q        <= '0;
            blank_q       <= '0;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
        end else begin
            sync1_q       <= {an, seg};
            sync2_q       <= sync1_q;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
            case (state_q)
                IDLE, HOLD: begin
                    if (sync2_q != last_q) begin
                        state_q <= SETTLE;
                        cnt_q   <= CNT_ONE;
                        last_q  <= sync2_q;
                    end
                end
                SETTLE: begin
                    if (sync2_q != last_q) begin
                        cnt_q  <= CNT_ONE;
                        last_q <= sync2_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (cnt_q == STABLE_LAST) state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_q <= HOLD;
                    if (cap_idle) begin
                        state_q <= IDLE;
                    end else if (cap_multi) begin
                        err_anode_q <= 1'b1;
                    end else if (!cap_dec.valid) begin
                        err_pattern_q <= 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (cap_an_low[i]) begin
                                digits_q[4*i +: 4] <= cap_dec.value;
                                seen_q[i]          <= 1'b1;
                                blank_q[i]         <= cap_dec.blank;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign digits      = digits_q;
    assign digit_seen  = seen_q;
    assign blank_mask  = blank_q;
    assign frame_valid = &seen_q;
    assign err_pattern = err_pattern_q;
    assign err_anode   = err_anode_q;

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Self-checking bench for ssd_scan_decoder: directed vector table, reset abort case, and
// randomized bus traffic compared every cycle against a run-length reference model.
module tb_ssd_scan_decoder;

    localparam int ND = 4;
    localparam int S  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] digits;
    logic [3:0]  digit_seen, blank_mask;
    logic        frame_valid, err_pattern, err_anode;

    ssd_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .an(an), .seg(seg),
        .digits(digits), .digit_seen(digit_seen), .blank_mask(blank_mask),
        .frame_valid(frame_valid), .err_pattern(err_pattern), .err_anode(err_anode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference glyph table: entries 0..9 always legal, 10..15 only with hex decode.
    localparam logic [6:0] PATS [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
        7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
`ifdef SSD_HEX_DECODE_EN
    localparam int N_LEGAL = 16;
`else
    localparam int N_LEGAL = 10;
`endif

    // Model: the bus is seen two edges late; a run of S identical samples is captured once,
    // one edge later, and a new run can only start after that capture edge.
    logic [10:0] hist0, hist1, m_prev;
    int          m_run;
    bit          m_wait, m_cap;
    logic [15:0] m_digits;
    logic [3:0]  m_seen, m_blank;
    bit          m_errp, m_erra;

    task automatic model_reset();
        hist0 = '1; hist1 = '1; m_prev = '1;
        m_run = 0; m_wait = 1; m_cap = 0;
        m_digits = '0; m_seen = '0; m_blank = '0;
        m_errp = 0; m_erra = 0;
    endtask

    task automatic model_capture(input logic [10:0] v);
        logic [3:0] a_low;
        int         pos;
        bit         ok;
        logic [3:0] val;
        a_low = ~v[10:7];
        ok = 0; val = 4'h0; pos = 0;
        if (a_low == 4'h0) return;
        if ($countones(a_low) > 1) begin
            m_erra = 1;
            return;
        end
        for (int i = 0; i < 4; i++) if (a_low[i]) pos = i;
        for (int k = 0; k < N_LEGAL; k++) if (PATS[k] == v[6:0]) begin ok = 1; val = 4'(k); end
        if (v[6:0] == 7'b1111111) begin
            m_digits[4*pos +: 4] = 4'hF;
            m_seen[pos]  = 1'b1;
            m_blank[pos] = 1'b1;
        end else if (ok) begin
            m_digits[4*pos +: 4] = val;
            m_seen[pos]  = 1'b1;
            m_blank[pos] = 1'b0;
        end else begin
            m_errp = 1;
        end
    endtask

    task automatic model_edge(input logic [10:0] x_in);
        logic [10:0] x;
        x = hist1;
        hist1 = hist0;
        hist0 = x_in;
        m_errp = 0; m_erra = 0;
        if (m_cap) begin
            model_capture(m_prev);
            m_cap = 0; m_wait = 1;
        end else if (m_wait) begin
            if (x != m_prev) begin m_prev = x; m_run = 1; m_wait = 0; end
        end else begin
            if (x == m_prev) m_run++;
            else begin m_prev = x; m_run = 1; end
            if (m_run == S) m_cap = 1;
        end
    endtask

    int errp_cnt, erra_cnt;

    task automatic cycle(input logic [3:0] a, input logic [6:0] s);
        an = a; seg = s;
        @(posedge clk);
        model_edge({a, s});
        @(negedge clk);
        check("per-cycle outputs",
              32'({digits, digit_seen, blank_mask, frame_valid, err_pattern, err_anode}),
              32'({m_digits, m_seen, m_blank, &m_seen, m_errp, m_erra}));
        if (err_pattern) errp_cnt++;
        if (err_anode)   erra_cnt++;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] digits;
        logic [3:0]  seen;
        logic [3:0]  blank;
        int          errp;
        int          erra;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int n;
        logic [3:0] ra;
        logic [6:0] rs;

`ifdef SSD_HEX_DECODE_EN
        localparam logic [15:0] D_AFTER_A = 16'h3F1A;
        localparam int          E_AFTER_A = 0;
`else
        localparam logic [15:0] D_AFTER_A = 16'h3F10;
        localparam int          E_AFTER_A = 1;
`endif
        vecs.push_back('{4'b1110, 7'b0100100, 20, 16'h0002, 4'b0001, 4'b0000, 0, 0});
        vecs.push_back('{4'b1110, 7'b1000000, 32, 16'h0000, 4'b0001, 4'b0000, 0, 0});
        vecs.push_back('{4'b1101, 7'b1111001, 32, 16'h0010, 4'b0011, 4'b0000, 0, 0});
        vecs.push_back('{4'b1011, 7'b0100100, 32, 16'h0210, 4'b0111, 4'b0000, 0, 0});
        vecs.push_back('{4'b0111, 7'b0110000, 32, 16'h3210, 4'b1111, 4'b0000, 0, 0});
        for (int k = 0; k < 6; k++)
            vecs.push_back('{4'b1101, (k % 2 == 0) ? 7'b1111000 : 7'b1111001, 8,
                             16'h3210, 4'b1111, 4'b0000, 0, 0});
        vecs.push_back('{4'b1011, 7'b1111111, 20, 16'h3F10, 4'b1111, 4'b0100, 0, 0});
        vecs.push_back('{4'b0011, 7'b1111111, 20, 16'h3F10, 4'b1111, 4'b0100, 0, 1});
        vecs.push_back('{4'b1110, 7'b0001000, 20, D_AFTER_A, 4'b1111, 4'b0100, E_AFTER_A, 0});
        vecs.push_back('{4'b1111, 7'b0000000, 20, D_AFTER_A, 4'b1111, 4'b0100, 0, 0});
        vecs.push_back('{4'b1011, 7'b0000000, 20, D_AFTER_A ^ 16'h0700, 4'b1111, 4'b0000, 0, 0});

        rst_n = 1'b0; an = '1; seg = '1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset outputs",
              32'({digits, digit_seen, blank_mask, frame_valid, err_pattern, err_anode}), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[r]) begin
            errp_cnt = 0; erra_cnt = 0;
            repeat (vecs[r].hold) cycle(vecs[r].an, vecs[r].seg);
            check($sformatf("row%0d digits", r), 32'(digits), 32'(vecs[r].digits));
            check($sformatf("row%0d digit_seen", r), 32'(digit_seen), 32'(vecs[r].seen));
            check($sformatf("row%0d blank_mask", r), 32'(blank_mask), 32'(vecs[r].blank));
            check($sformatf("row%0d frame_valid", r), 32'(frame_valid), 32'(vecs[r].seen == 4'hF));
            check($sformatf("row%0d err_pattern pulses", r), 32'(errp_cnt), 32'(vecs[r].errp));
            check($sformatf("row%0d err_anode pulses", r), 32'(erra_cnt), 32'(vecs[r].erra));
        end

        // Reset while a valid '5' on position 3 is still settling.
        repeat (10) cycle(4'b0111, 7'b0010010);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset clears outputs",
              32'({digits, digit_seen, blank_mask, frame_valid, err_pattern, err_anode}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!digit_seen[3] && n < 40) begin
            cycle(4'b0111, 7'b0010010);
            n++;
        end
        check("recapture latency after reset", 32'(n), 32'(2 + S + 1));
        check("recaptured digit", 32'(digits[15:12]), 32'h5);
        check("other positions stay clear", 32'(digit_seen[2:0]), 32'h0);

        // Randomized bus traffic with random run lengths around the stability threshold.
        for (int t = 0; t < 400; t++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 75)      ra = ~(4'b0001 << $urandom_range(0, 3));
            else if (sel < 85) ra = 4'hF;
            else               ra = 4'($urandom);
            if ($urandom_range(0, 9) < 6) rs = PATS[$urandom_range(0, 15)];
            else if ($urandom_range(0, 9) < 2) rs = 7'b1111111;
            else rs = 7'($urandom);
            repeat ($urandom_range(1, 40)) cycle(ra, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
